// File: rtl/gf233_mul_seq.sv
// Sequential GF(2^233) multiplier: 64 limb products through one registered 30x30
// carry-less core, then two folds modulo f(x) = x^233 + x^74 + 1.

module mult30 (
  input  logic        clk,
  input  logic [29:0] a_i,
  input  logic [29:0] b_i,
  output logic [59:0] p_o
);
  logic [59:0] p_d;
  logic [59:0] p_q;

  always_comb begin
    p_d = '0;
    for (int i = 0; i < 30; i++) begin
      if (b_i[i]) p_d = p_d ^ ({30'b0, a_i} << i);
    end
  end

  // Registered product: one-cycle latency, data-only (no reset).
  always_ff @(posedge clk) begin
    p_q <= p_d;
  end

  assign p_o = p_q;
endmodule

module gf233_mul_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [232:0] a,
  input  logic [232:0] b,
  output logic         busy,
  output logic         done,
  output logic [232:0] c
);
  localparam int M      = 233;
  localparam int K      = 74;
  localparam int LIMB_W = 30;
  localparam int OP_W   = 240;
  localparam int ACC_W  = 480;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_RED1  = 3'd3;
  localparam logic [2:0] S_RED2  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [M-1:0]     c_q, c_d;
  logic             done_q, done_d;
  logic             vld_q, vld_d;
  logic [3:0]       s_q, s_d;
  logic [OP_W-1:0]  a_q, b_q;
  logic [LIMB_W-1:0] mul_a, mul_b;
  logic [59:0]      prod;
  logic [ACC_W-1:0] prod_x;
  logic             accept;

  // First fold: bits 233..464 folded back via x^233 = x^74 + 1 (result degree <= 305).
  function automatic logic [ACC_W-1:0] fold_hi(input logic [ACC_W-1:0] x);
    logic [ACC_W-1:0] hx;
    logic [ACC_W-1:0] r;
    hx = '0;
    hx[231:0] = x[464:233];
    r = '0;
    r[M-1:0] = x[M-1:0];
    return r ^ hx ^ (hx << K);
  endfunction

  // Second fold: remaining bits 233..305 (g << 74 stays below bit 233).
  function automatic logic [M-1:0] fold_lo(input logic [ACC_W-1:0] x);
    logic [M-1:0] gx;
    gx = '0;
    gx[72:0] = x[305:233];
    return x[M-1:0] ^ gx ^ (gx << K);
  endfunction

  assign accept = (state_q == S_IDLE) && start;
  assign mul_a  = a_q[LIMB_W*int'(cnt_q[5:3]) +: LIMB_W];
  assign mul_b  = b_q[LIMB_W*int'(cnt_q[2:0]) +: LIMB_W];
  assign prod_x = {{(ACC_W-60){1'b0}}, prod};

  mult30 u_mult30 (
    .clk (clk),
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    c_d     = c_q;
    done_d  = 1'b0;
    vld_d   = (state_q == S_MUL);
    s_d     = {1'b0, cnt_q[5:3]} + {1'b0, cnt_q[2:0]};
    if (vld_q) acc_d = acc_q ^ (prod_x << (LIMB_W * int'(s_q)));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MUL;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_RED1;
      S_RED1: begin
        acc_d   = fold_hi(acc_q);
        state_d = S_RED2;
      end
      S_RED2: begin
        c_d     = fold_lo(acc_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
    end
  end

  // Operands and the shift index are pure data; validity is carried by vld_q.
  always_ff @(posedge clk) begin
    s_q <= s_d;
    if (accept) begin
      a_q <= {{(OP_W-M){1'b0}}, a};
      b_q <= {{(OP_W-M){1'b0}}, b};
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign c    = c_q;
endmodule

// File: tb/tb_gf233_mul_seq.sv
// Scoreboard bench for gf233_mul_seq: driver queues expected products, a monitor
// checks c, latency and busy length whenever done pulses.

module tb_gf233_mul_seq;
  localparam logic [233:0] F = (234'd1 << 233) | (234'd1 << 74) | 234'd1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [232:0] a = '0;
  logic [232:0] b = '0;
  logic         busy;
  logic         done;
  logic [232:0] c;

  gf233_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [232:0] c;
    int           issue;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bit-serial reference: Horner over the bits of y, reducing by f(x) each step.
  function automatic logic [232:0] gf_mul(input logic [232:0] x, input logic [232:0] y);
    logic [233:0] r;
    r = '0;
    for (int i = 232; i >= 0; i--) begin
      r = r << 1;
      if (r[233]) r = r ^ F;
      if (y[i]) r[232:0] = r[232:0] ^ x;
    end
    return r[232:0];
  endfunction

  function automatic logic [232:0] rnd233();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    return w[232:0];
  endfunction

  function automatic logic [232:0] mono(input int e);
    logic [232:0] m;
    m = '0;
    m[e] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [232:0] act, input logic [232:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done and tracks busy run length.
  initial begin
    exp_t e;
    int   busy_run;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        else if (busy_run > 0) begin
          chk_int("busy_len", busy_run, 67);
          busy_run = 0;
        end
        if (done) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 with nothing pending, required done=0");
          end else begin
            e = sb.pop_front();
            chk("c", c, e.c);
            chk_int("latency", cyc - e.issue, 67);
          end
        end
      end
    end
  end

  // Called at a negedge; waits for idle, then requests one operation.
  task automatic issue(input logic [232:0] x, input logic [232:0] y, input logic [232:0] expv);
    int g;
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: busy=%0b required 0", busy);
    end
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back('{expv, cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_quiet();
    int g;
    g = 0;
    while ((busy || sb.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (busy || sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL quiet_timeout: busy=%0b pending=%0d required 0/0", busy, sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_int({tag, "_busy"}, int'(busy), 0);
    chk_int({tag, "_done"}, int'(done), 0);
    chk({tag, "_c"}, c, '0);
  endtask

  initial begin
    logic [232:0] x1, y1, x2, y2, ones;
    int g;
    ones = '1;

    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Directed products with hand-derived reductions.
    issue(mono(0), mono(0), mono(0));
    issue(mono(232), mono(1), mono(74) | mono(0));
    issue(mono(232), mono(232), mono(231) | mono(146) | mono(72));
    issue('0, ones, '0);
    wait_quiet();

    // start held high through the done cycle: second op begins with no idle gap.
    x1 = rnd233(); y1 = rnd233(); x2 = rnd233(); y2 = rnd233();
    a = x1; b = y1; start = 1'b1;
    sb.push_back('{gf_mul(x1, y1), cyc + 1});
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!done && g < 100);
    a = x2; b = y2;
    sb.push_back('{gf_mul(x2, y2), cyc + 1});
    @(negedge clk);
    start = 1'b0;
    wait_quiet();

    // start pulsed mid-operation with other operands must be ignored.
    x1 = rnd233(); y1 = rnd233();
    issue(x1, y1, gf_mul(x1, y1));
    repeat (19) @(negedge clk);
    a = rnd233(); b = rnd233(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet();
    chk("c_hold", c, gf_mul(x1, y1));

    // Random operations, back to back.
    for (int n = 0; n < 700; n++) begin
      x1 = rnd233();
      y1 = rnd233();
      issue(x1, y1, gf_mul(x1, y1));
    end
    wait_quiet();

    // Reset during MUL cycle 30: discarded, no done.
    a = rnd233(); b = rnd233(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mul");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset during RED1 (cycle 66).
    a = rnd233(); b = rnd233(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (65) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_red1");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk_int("no_done_after_reset_c", int'(c == '0), 1);

    issue(mono(100), mono(200), mono(141) | mono(67));
    wait_quiet();
    chk("c_after_reset", c, mono(141) | mono(67));

    repeat (5) @(negedge clk);
    chk_int("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
